// File: rtl/mseq_pkg.sv
// Shared definitions for the micro_sequencer: sequencing opcodes, FSM states,
// ALU operation codes and helpers that locate fields inside a microinstruction.
package mseq_pkg;

   // Sequencing opcode carried in every microinstruction.
   typedef enum logic [1:0] {
      SEQ_NEXT   = 2'b00,
      SEQ_JUMP   = 2'b01,
      SEQ_BRANCH = 2'b10,
      SEQ_HALT   = 2'b11
   } seq_op_e;

   // Sequencer control states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // ALU operation codes placed in the ALUop field of machineCode.
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   // Fixed low-order bit positions inside the control field.
   localparam int OUTLOAD_BIT = 32'sd0;
   localparam int ALUOP_LSB   = 32'sd1;
   localparam int WR_EN_BIT   = 32'sd3;
   localparam int WADDR_LSB   = 32'sd4;

   // Width of the control field (machineCode).
   function automatic int mc_width(input int reg_aw);
      return 32'sd5 + 32'sd3 * reg_aw;
   endfunction

   // Lowest bit of raddr2 inside the control field.
   function automatic int raddr2_lsb(input int reg_aw);
      return WADDR_LSB + reg_aw;
   endfunction

   // Lowest bit of raddr1 inside the control field.
   function automatic int raddr1_lsb(input int reg_aw);
      return WADDR_LSB + 32'sd2 * reg_aw;
   endfunction

   // Position of RFSrcMuxSel (the control field MSB).
   function automatic int rf_src_bit(input int reg_aw);
      return WADDR_LSB + 32'sd3 * reg_aw;
   endfunction

   // Lowest bit of seq_op inside a full microinstruction.
   function automatic int seq_op_lsb(input int pc_w);
      return pc_w;
   endfunction

   // Lowest bit of the control field inside a full microinstruction.
   function automatic int control_lsb(input int pc_w);
      return pc_w + 32'sd2;
   endfunction

   // Width of a full microinstruction word.
   function automatic int ui_width(input int reg_aw, input int pc_w);
      return mc_width(reg_aw) + 32'sd2 + pc_w;
   endfunction

endpackage

// File: rtl/mseq_prog_mem.sv
// Microprogram store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not touched by reset so a program survives it.
module mseq_prog_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 20
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Write port: store a word on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetches microinstructions from mseq_prog_mem,
// drives their control field on machineCode and steps the PC according to
// NEXT / JUMP / BRANCH / HALT. Optional single-step mode: define MSEQ_STEP_EN
// to add a step input that gates every RUN-state advance.
module micro_sequencer
   import mseq_pkg::*;
#(
   parameter int   REG_AW     = 3,
   parameter int   PROG_DEPTH = 16,
   localparam int  PC_W       = $clog2(PROG_DEPTH),
   localparam int  MC_W       = mc_width(REG_AW),
   localparam int  UI_W       = ui_width(REG_AW, PC_W)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            cond,
`ifdef MSEQ_STEP_EN
   input  logic            step,
`endif
   input  logic            prog_we,
   input  logic [PC_W-1:0] prog_addr,
   input  logic [UI_W-1:0] prog_wdata,
   output logic [MC_W-1:0] machineCode,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            done
);

   localparam int CTRL_LSB = control_lsb(PC_W);
   localparam int OP_LSB   = seq_op_lsb(PC_W);

   state_e          state;
   state_e          state_next;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] pc_inc;
   logic [UI_W-1:0] word;
   logic [MC_W-1:0] ctrl;
   logic [PC_W-1:0] target;
   seq_op_e         op;
   logic            mem_we;
   logic            advance;

   // Writes land only while the sequencer is not executing; reset wins.
   assign mem_we = prog_we & ~reset & ((state == ST_IDLE) | (state == ST_DONE));

   mseq_prog_mem #(
      .DEPTH (PROG_DEPTH),
      .AW    (PC_W),
      .DW    (UI_W)
   ) u_prog_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (prog_addr),
      .wdata (prog_wdata),
      .raddr (pc),
      .rdata (word)
   );

   assign ctrl   = word[UI_W-1:CTRL_LSB];
   assign op     = seq_op_e'(word[OP_LSB+1:OP_LSB]);
   assign target = word[PC_W-1:0];
   // PROG_DEPTH is a power of two, so natural overflow gives the wrap to 0.
   assign pc_inc = pc + PC_W'(1'b1);

`ifdef MSEQ_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   // Next-state, next-pc and output decode; cond only steers pc_next.
   always_comb begin
      state_next  = state;
      pc_next     = pc;
      machineCode = '0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
               pc_next    = '0;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            busy        = 1'b1;
            machineCode = ctrl;
`ifdef MSEQ_STEP_EN
            if (!step) begin
               machineCode[WR_EN_BIT]   = 1'b0;
               machineCode[OUTLOAD_BIT] = 1'b0;
            end else begin
               machineCode = ctrl;
            end
`endif
            if (advance) begin
               case (op)
                  SEQ_NEXT:   pc_next = pc_inc;
                  SEQ_JUMP:   pc_next = target;
                  SEQ_BRANCH: pc_next = cond ? target : pc_inc;
                  SEQ_HALT:   state_next = ST_DONE;
                  default:    state_next = ST_IDLE;
               endcase
            end else begin
               pc_next = pc;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            pc_next    = '0;
         end
      endcase
   end

   // State and program-counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         pc    <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus a random
// phase, all compared against a behavioural model of the sequencer.
// Build with MSEQ_STEP_EN defined to exercise the single-step port.
module tb_micro_sequencer;

   localparam int REG_AW = 3;
   localparam int DEPTH  = 16;
   localparam int PC_W   = 4;
   localparam int MC_W   = 14;
   localparam int UI_W   = 20;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            cond;
   logic            step;
   logic            prog_we;
   logic [PC_W-1:0] prog_addr;
   logic [UI_W-1:0] prog_wdata;
   logic [MC_W-1:0] machineCode;
   logic [PC_W-1:0] pc;
   logic            busy;
   logic            done;

   int total = 0;
   int bad   = 0;

   // Behavioural model: mode 0 = idle, 1 = executing, 2 = completion cycle.
   int m_mode = 0;
   int m_pc   = 0;
   int m_mem [DEPTH];
   int lin [11];
   int pcs [$];

   always #5 clk = ~clk;

   micro_sequencer #(.REG_AW(REG_AW), .PROG_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cond        (cond),
`ifdef MSEQ_STEP_EN
      .step        (step),
`endif
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_wdata  (prog_wdata),
      .machineCode (machineCode),
      .pc          (pc),
      .busy        (busy),
      .done        (done)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Build a microinstruction from its fields with plain arithmetic.
   function automatic int mk(int src, int ra1, int ra2, int wa, int we, int alu, int outl, int op, int tgt);
      int c;
      c = ((((((src * 8 + ra1) * 8 + ra2) * 8 + wa) * 2 + we) * 4 + alu) * 2) + outl;
      return (c * 4 + op) * DEPTH + tgt;
   endfunction

   function automatic int ctrl_of(int w);
      return w / (DEPTH * 4);
   endfunction

   function automatic int op_of(int w);
      return (w / DEPTH) % 4;
   endfunction

   task automatic model_edge();
      int w;
      bit adv;
`ifdef MSEQ_STEP_EN
      adv = step;
`else
      adv = 1'b1;
`endif
      if (reset) begin
         m_mode = 0;
         m_pc   = 0;
      end else if (m_mode == 0) begin
         if (prog_we) m_mem[prog_addr] = int'(prog_wdata);
         if (start) begin
            m_mode = 1;
            m_pc   = 0;
         end
      end else if (m_mode == 2) begin
         if (prog_we) m_mem[prog_addr] = int'(prog_wdata);
         m_mode = 0;
      end else if (adv) begin
         w = m_mem[m_pc];
         case (op_of(w))
            0:       m_pc = (m_pc + 1) % DEPTH;
            1:       m_pc = w % DEPTH;
            2:       m_pc = cond ? (w % DEPTH) : (m_pc + 1) % DEPTH;
            default: m_mode = 2;
         endcase
      end
   endtask

   task automatic check_outputs();
      int exp_mc;
      exp_mc = (m_mode == 1) ? ctrl_of(m_mem[m_pc]) : 0;
`ifdef MSEQ_STEP_EN
      if (m_mode == 1 && !step) exp_mc = exp_mc & 32'hFFFF_FFF6;
`endif
      check_val("mc", 32'(machineCode), exp_mc);
      check_val("pc", 32'(pc), m_pc);
      check_val("busy", 32'(busy), (m_mode == 1) ? 1 : 0);
      check_val("done", 32'(done), (m_mode == 2) ? 1 : 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic load_word(input int addr, input int data);
      prog_we    = 1'b1;
      prog_addr  = PC_W'(addr);
      prog_wdata = UI_W'(data);
      cyc();
      prog_we    = 1'b0;
   endtask

   task automatic run_to_idle();
      int n;
      n = 0;
      while ((busy || done) && n < 60) begin
         cyc();
         n++;
      end
      check_val("run_bound", 32'(busy || done), 0);
   endtask

   // Start a run with the given cond and record the pc of every RUN cycle.
   task automatic run_trace(input logic c);
      int n;
      cond  = c;
      start = 1'b1;
      cyc();
      start = 1'b0;
      pcs.delete();
      n = 0;
      while (busy && n < 40) begin
         pcs.push_back(int'(pc));
         cyc();
         n++;
      end
      run_to_idle();
   endtask

   initial begin
      int n;
      int exp_br [4];
      int exp_wrap [4];

      reset = 1'b1; start = 1'b0; cond = 1'b0; step = 1'b1;
      prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
      @(negedge clk);
      cyc(); cyc();
      reset = 1'b0;
      // Idle after reset: everything quiet.
      for (int i = 0; i < 5; i++) begin
         cyc();
         check_val("idle_mc", 32'(machineCode), 0);
         check_val("idle_pc", 32'(pc), 0);
         check_val("idle_busy", 32'(busy), 0);
         check_val("idle_done", 32'(done), 0);
      end

      // Fill memory with HALT words so the model and DUT start aligned.
      for (int i = 0; i < DEPTH; i++) load_word(i, mk(0, 0, 0, 0, 0, 0, 0, 3, 0));

      // Linear program.
      lin[0]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0);
      lin[1]  = mk(0, 0, 0, 2, 1, 0, 0, 0, 0);
      lin[2]  = mk(0, 0, 0, 3, 1, 0, 0, 0, 0);
      lin[3]  = mk(1, 1, 3, 1, 1, 0, 0, 0, 0);
      lin[4]  = mk(1, 2, 3, 2, 1, 0, 0, 0, 0);
      lin[5]  = mk(1, 1, 2, 3, 1, 1, 0, 0, 0);
      lin[6]  = mk(1, 1, 3, 4, 1, 2, 0, 0, 0);
      lin[7]  = mk(1, 2, 3, 5, 1, 3, 0, 0, 0);
      lin[8]  = mk(1, 1, 2, 6, 1, 0, 0, 0, 0);
      lin[9]  = mk(1, 2, 6, 7, 1, 0, 0, 0, 0);
      lin[10] = mk(0, 7, 7, 0, 0, 0, 1, 3, 0);
      for (int i = 0; i < 11; i++) load_word(i, lin[i]);
      start = 1'b1;
      cyc();
      start = 1'b0;
      check_val("w0_mc", 32'(machineCode), 32'h018);
      n = 0;
      while (!done && n < 40) begin
         if (busy && pc == 4'd10) check_val("last_mc", 32'(machineCode), 32'h1F81);
         cyc();
         n++;
      end
      check_val("done_lat", n, 11);
      cyc();
      check_val("done_1cyc", 32'(done), 0);

      // Branch at word 2 to word 7.
      load_word(0, mk(0, 1, 1, 1, 1, 0, 0, 0, 0));
      load_word(1, mk(0, 2, 2, 2, 1, 0, 0, 0, 0));
      load_word(2, mk(1, 3, 3, 3, 1, 1, 0, 2, 7));
      load_word(3, mk(0, 4, 4, 4, 0, 0, 1, 3, 0));
      load_word(7, mk(0, 5, 5, 5, 0, 0, 1, 3, 0));
      exp_br = '{0, 1, 2, 7};
      run_trace(1'b1);
      check_val("br_taken_len", pcs.size(), 4);
      for (int i = 0; i < 4 && i < pcs.size(); i++) check_val("br_taken_pc", pcs[i], exp_br[i]);
      exp_br = '{0, 1, 2, 3};
      run_trace(1'b0);
      check_val("br_fall_len", pcs.size(), 4);
      for (int i = 0; i < 4 && i < pcs.size(); i++) check_val("br_fall_pc", pcs[i], exp_br[i]);

      // Wrap 15 -> 0 and JUMP 0 -> 15.
      load_word(0, mk(0, 1, 2, 3, 1, 0, 0, 1, 15));
      load_word(15, mk(1, 3, 2, 1, 1, 3, 0, 0, 0));
      exp_wrap = '{15, 0, 15, 0};
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check_val("wrap_pc", 32'(pc), exp_wrap[i]);
         check_val("wrap_busy", 32'(busy), 1);
      end
      reset = 1'b1;
      cyc();
      reset = 1'b0;

      // Protection: write during RUN dropped, reset mid-run.
      for (int i = 0; i < 11; i++) load_word(i, lin[i]);
      start = 1'b1;
      cyc();
      start = 1'b0;
      n = 0;
      while (pc != 4'd5 && n < 20) begin
         prog_we    = (pc == 4'd1);
         prog_addr  = 4'd3;
         prog_wdata = 20'hFFFFF;
         cyc();
         n++;
      end
      prog_we = 1'b0;
      check_val("prot_reach", 32'(pc), 5);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_val("rst_pc", 32'(pc), 0);
      check_val("rst_busy", 32'(busy), 0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      n = 0;
      while (pc != 4'd3 && n < 20) begin
         cyc();
         n++;
      end
      check_val("prot_mem3", 32'(machineCode), ctrl_of(lin[3]));
      run_to_idle();

      // Write and start in the same IDLE cycle.
      prog_we    = 1'b1;
      prog_addr  = 4'd0;
      prog_wdata = UI_W'(mk(1, 6, 5, 4, 1, 2, 1, 3, 0));
      start      = 1'b1;
      cyc();
      prog_we = 1'b0;
      start   = 1'b0;
      check_val("sw_mc", 32'(machineCode), ctrl_of(mk(1, 6, 5, 4, 1, 2, 1, 3, 0)));
      run_to_idle();

`ifdef MSEQ_STEP_EN
      // Single-step: advance on every third cycle only.
      for (int i = 0; i < 11; i++) load_word(i, lin[i]);
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 45 && busy; i++) begin
         step = (i % 3 == 2);
         cyc();
         if (busy && !step) check_val("step_wren", 32'(machineCode[3]), 0);
      end
      step = 1'b1;
      run_to_idle();
`endif

      // Random phase.
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 49) == 0);
         start      = ($urandom_range(0, 3) == 0);
         cond       = 1'($urandom);
         prog_we    = ($urandom_range(0, 2) == 0);
         prog_addr  = PC_W'($urandom);
         prog_wdata = UI_W'($urandom);
`ifdef MSEQ_STEP_EN
         step       = 1'($urandom);
`endif
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
